// File: rtl/regfile_rw_if.sv
// Register-file port bundle: one write port from writeback, two read ports from decode.
// The master drives requests; the slave (register file) returns read data and the init stall.
interface regfile_rw_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              init_busy;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, init_busy
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, init_busy
    );
endinterface

// File: rtl/regfile_rw.sv
// General-purpose register file: two combinational read ports with write bypass, one write port,
// r0 hard-wired to zero, and a post-reset sweep that zeroes the un-reset storage array.
module regfile_rw #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input logic         clk,
    input logic         rst,
    regfile_rw_if.slave bus
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;
    logic              sweep_we;
    logic              user_we;
    logic              busy;
    logic              active;

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            ptr   <= FIRST_REG;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // The sweep stops on the last register without incrementing, so ptr never wraps to r0.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        sweep_we   = 1'b0;
        user_we    = 1'b0;
        busy       = 1'b1;
        case (state)
            INIT: begin
                sweep_we = 1'b1;
                if (ptr == LAST_REG) begin
                    state_next = RUN;
                end else begin
                    ptr_next = ptr + FIRST_REG;
                end
            end
            RUN: begin
                busy    = 1'b0;
                user_we = bus.we && (bus.waddr != '0);
            end
            default: begin
                state_next = INIT;
            end
        endcase
        if (rst) begin
            sweep_we = 1'b0;
            user_we  = 1'b0;
            busy     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[ptr] <= '0;
        end else if (user_we) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    assign active = !rst && (state == RUN);

    // Read priority: inactive, disabled port and r0 all yield zero before bypass or storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              port_active,
        input logic              en,
        input logic [ADDR_W-1:0] addr,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] result;
        result = '0;
        if (port_active && en && (addr != '0)) begin
            if (wr_en && (wr_addr == addr)) begin
                result = wr_data;
            end else begin
                result = stored;
            end
        end
        return result;
    endfunction

    always_comb begin
        bus.rdata1 = '0;
        bus.rdata1 = read_port(active, bus.re1, bus.raddr1, bus.we, bus.waddr,
                               bus.wdata, mem[bus.raddr1]);
    end

    always_comb begin
        bus.rdata2 = '0;
        bus.rdata2 = read_port(active, bus.re2, bus.raddr2, bus.we, bus.waddr,
                               bus.wdata, mem[bus.raddr2]);
    end

    assign bus.init_busy = busy;

endmodule
